// File: rtl/pipe_ctrl.sv
// Pipeline stall/flush/redirect producer: stall is zero-latency from requests; flush/redirect register one cycle after detection or after bus drain.
// No backpressure of its own (consumers only sample); optional counters under `PIPE_CTRL_PERF_EN`.
module pipe_ctrl #(
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int PERF_W         = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stallreq_if,
    input  logic              stallreq_id,
    input  logic              stallreq_ex,
    input  logic              stallreq_mem,
    input  logic              excp_valid,
    input  logic              excp_is_ertn,
    input  logic [31:0]       excp_eentry,
    input  logic [31:0]       excp_era,
    input  logic              bus_busy,
    output logic [6:0]        stall,
    output logic              flush,
    output logic              redirect_valid,
    output logic [31:0]       redirect_pc,
    output logic [1:0]        ctrl_state,
    output logic              stall_timeout
`ifdef PIPE_CTRL_PERF_EN
    ,
    output logic [PERF_W-1:0] perf_stall_cycles,
    output logic [PERF_W-1:0] perf_flush_count
`endif
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_WAIT_BUS = 2'd1,
        ST_FLUSH    = 2'd2
    } state_t;

    state_t           r_state;
    logic             r_flush;
    logic             r_redirect_valid;
    logic [31:0]      r_redirect_pc;
    logic             r_timeout;
    logic [CNT_W-1:0] r_wd_cnt;
    logic [CNT_W-1:0] w_wd_nxt;
    logic [6:0]       w_stall;

    // Requests are masked while reset is held so nothing downstream freezes.
    always_comb begin
        w_stall = 7'h00;
        if (rst) begin
            case (r_state)
                ST_RUN: begin
                    if (excp_valid)        w_stall = 7'h7F;
                    else if (stallreq_mem) w_stall = 7'b0111111;
                    else if (stallreq_ex)  w_stall = 7'b0011111;
                    else if (stallreq_id)  w_stall = 7'b0001111;
                    else if (stallreq_if)  w_stall = 7'b0000111;
                    else                   w_stall = 7'h00;
                end
                ST_WAIT_BUS: w_stall = 7'h7F;
                default:     w_stall = 7'h00;
            endcase
        end
    end

    always_comb begin
        w_wd_nxt = '0;
        if (w_stall != 7'h00) begin
            if (r_wd_cnt == CNT_W'(TIMEOUT_CYCLES)) w_wd_nxt = r_wd_cnt;
            else                                    w_wd_nxt = r_wd_cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wd_cnt  <= '0;
            r_timeout <= 1'b0;
        end else begin
            r_wd_cnt  <= w_wd_nxt;
            r_timeout <= r_timeout | (w_wd_nxt == CNT_W'(TIMEOUT_CYCLES));
        end
    end

    // Target is latched at detection; exceptions seen in WAIT_BUS or FLUSH are dropped.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state          <= ST_RUN;
            r_flush          <= 1'b0;
            r_redirect_valid <= 1'b0;
            r_redirect_pc    <= 32'h0;
        end else begin
            r_flush          <= 1'b0;
            r_redirect_valid <= 1'b0;
            case (r_state)
                ST_RUN: begin
                    if (excp_valid) begin
                        r_redirect_pc <= excp_is_ertn ? excp_era : excp_eentry;
                        if (bus_busy) begin
                            r_state <= ST_WAIT_BUS;
                        end else begin
                            r_state          <= ST_FLUSH;
                            r_flush          <= 1'b1;
                            r_redirect_valid <= 1'b1;
                        end
                    end
                end
                ST_WAIT_BUS: begin
                    if (!bus_busy) begin
                        r_state          <= ST_FLUSH;
                        r_flush          <= 1'b1;
                        r_redirect_valid <= 1'b1;
                    end
                end
                default: r_state <= ST_RUN;
            endcase
        end
    end

`ifdef PIPE_CTRL_PERF_EN
    logic [PERF_W-1:0] r_perf_stall;
    logic [PERF_W-1:0] r_perf_flush;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_perf_stall <= '0;
            r_perf_flush <= '0;
        end else begin
            if (w_stall[0])           r_perf_stall <= r_perf_stall + PERF_W'(1);
            if (r_state == ST_FLUSH)  r_perf_flush <= r_perf_flush + PERF_W'(1);
        end
    end

    assign perf_stall_cycles = r_perf_stall;
    assign perf_flush_count  = r_perf_flush;
`endif

    assign stall          = w_stall;
    assign flush          = r_flush;
    assign redirect_valid = r_redirect_valid;
    assign redirect_pc    = r_redirect_pc;
    assign ctrl_state     = r_state;
    assign stall_timeout  = r_timeout;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Scoreboarded bench for pipe_ctrl: per-cycle expected outputs queued at drive time, compared at the falling edge.
module tb_pipe_ctrl;

    logic        clk;
    logic        rst;
    logic        stallreq_if, stallreq_id, stallreq_ex, stallreq_mem;
    logic        excp_valid, excp_is_ertn;
    logic [31:0] excp_eentry, excp_era;
    logic        bus_busy;
    logic [6:0]  stall;
    logic        flush, redirect_valid;
    logic [31:0] redirect_pc;
    logic [1:0]  ctrl_state;
    logic        stall_timeout;
`ifdef PIPE_CTRL_PERF_EN
    logic [31:0] perf_stall_cycles, perf_flush_count;
`endif

    pipe_ctrl #(.TIMEOUT_CYCLES(8), .PERF_W(32)) dut (
        .clk            (clk),
        .rst            (rst),
        .stallreq_if    (stallreq_if),
        .stallreq_id    (stallreq_id),
        .stallreq_ex    (stallreq_ex),
        .stallreq_mem   (stallreq_mem),
        .excp_valid     (excp_valid),
        .excp_is_ertn   (excp_is_ertn),
        .excp_eentry    (excp_eentry),
        .excp_era       (excp_era),
        .bus_busy       (bus_busy),
        .stall          (stall),
        .flush          (flush),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .ctrl_state     (ctrl_state),
        .stall_timeout  (stall_timeout)
`ifdef PIPE_CTRL_PERF_EN
        ,
        .perf_stall_cycles (perf_stall_cycles),
        .perf_flush_count  (perf_flush_count)
`endif
    );

    typedef struct packed {
        logic [6:0]  stall;
        logic        flush;
        logic        rv;
        logic [1:0]  st;
        logic        to;
        logic        pc_chk;
        logic [31:0] pc;
    } exp_t;

    exp_t sb[$];
    exp_t e, o;
    int   n_chk  = 0;
    int   n_pass = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // redirect_pc is only meaningful while redirect_valid is expected high
    function automatic exp_t mk(input logic [6:0] s, input logic f, input logic rv,
                                input logic [1:0] st, input logic to, input logic [31:0] pc);
        exp_t x;
        x.stall = s; x.flush = f; x.rv = rv; x.st = st; x.to = to;
        x.pc_chk = rv;
        x.pc = rv ? pc : 32'h0;
        return x;
    endfunction

    function automatic exp_t obs(input logic chk);
        exp_t x;
        x.stall = stall; x.flush = flush; x.rv = redirect_valid; x.st = ctrl_state;
        x.to = stall_timeout; x.pc_chk = chk;
        x.pc = chk ? redirect_pc : 32'h0;
        return x;
    endfunction

    // req bits: {mem, ex, id, if}
    task automatic drive(input logic [3:0] req, input logic ev, input logic ertn,
                         input logic [31:0] ee, input logic [31:0] era, input logic busy);
        stallreq_if  = req[0];
        stallreq_id  = req[1];
        stallreq_ex  = req[2];
        stallreq_mem = req[3];
        excp_valid   = ev;
        excp_is_ertn = ertn;
        excp_eentry  = ee;
        excp_era     = era;
        bus_busy     = busy;
    endtask

    task automatic next_cycle;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        for (int i = 0; i < 3; i++) begin
            next_cycle();
            if (i < 2) drive(4'b1111, 1'b1, 1'b0, 32'h1C000100, 32'h0, 1'b1);
            else begin
                rst = 1'b1;
                drive(4'b0000, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
            end
            sb.push_back(mk(7'h00, 1'b0, 1'b0, 2'd0, 1'b0, 32'h0));
            @(negedge clk);
            e = sb.pop_front(); o = obs(e.pc_chk); n_chk++;
            if (o !== e) $display("FAIL reset cyc %0d: got %h want %h", i, o, e);
            else n_pass++;
        end
`ifdef PIPE_CTRL_PERF_EN
        n_chk++;
        if ({perf_stall_cycles, perf_flush_count} !== 64'h0)
            $display("FAIL reset_perf: got %h/%h want 0/0", perf_stall_cycles, perf_flush_count);
        else n_pass++;
`endif
    endtask

    task automatic test_stall_id;
        for (int i = 0; i < 4; i++) begin
            next_cycle();
            drive((i < 3) ? 4'b0010 : 4'b0000, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
            sb.push_back(mk((i < 3) ? 7'b0001111 : 7'h00, 1'b0, 1'b0, 2'd0, 1'b0, 32'h0));
            @(negedge clk);
            e = sb.pop_front(); o = obs(e.pc_chk); n_chk++;
            if (o !== e) $display("FAIL stall_id cyc %0d: got %h want %h", i, o, e);
            else n_pass++;
        end
    endtask

    task automatic test_stall_combo;
        logic [3:0] req;
        logic [6:0] exp_s;
        for (int i = 0; i < 5; i++) begin
            case (i)
                0:       begin req = 4'b0101; exp_s = 7'b0011111; end
                1:       begin req = 4'b1001; exp_s = 7'b0111111; end
                2:       begin req = 4'b0001; exp_s = 7'b0000111; end
                3:       begin req = 4'b1110; exp_s = 7'b0111111; end
                default: begin req = 4'b0000; exp_s = 7'b0000000; end
            endcase
            next_cycle();
            drive(req, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
            sb.push_back(mk(exp_s, 1'b0, 1'b0, 2'd0, 1'b0, 32'h0));
            @(negedge clk);
            e = sb.pop_front(); o = obs(e.pc_chk); n_chk++;
            if (o !== e) $display("FAIL stall_combo cyc %0d: got %h want %h", i, o, e);
            else n_pass++;
        end
    endtask

    task automatic test_excp;
        for (int i = 0; i < 4; i++) begin
            next_cycle();
            case (i)
                0: begin
                    drive(4'b0010, 1'b1, 1'b0, 32'h1C00_0100, 32'hDEAD_0000, 1'b0);
                    sb.push_back(mk(7'h7F, 1'b0, 1'b0, 2'd0, 1'b0, 32'h0));
                end
                1: begin
                    drive(4'b0100, 1'b1, 1'b0, 32'h1234_5678, 32'h0, 1'b0);
                    sb.push_back(mk(7'h00, 1'b1, 1'b1, 2'd2, 1'b0, 32'h1C00_0100));
                end
                default: begin
                    drive(4'b0000, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
                    sb.push_back(mk(7'h00, 1'b0, 1'b0, 2'd0, 1'b0, 32'h0));
                end
            endcase
            @(negedge clk);
            e = sb.pop_front(); o = obs(e.pc_chk); n_chk++;
            if (o !== e) $display("FAIL excp cyc %0d: got %h want %h", i, o, e);
            else n_pass++;
        end
    endtask

    task automatic test_ertn_wait;
        for (int i = 0; i < 8; i++) begin
            next_cycle();
            if (i == 0) begin
                drive(4'b0000, 1'b1, 1'b1, 32'h1C00_0100, 32'h1C00_2000, 1'b1);
                sb.push_back(mk(7'h7F, 1'b0, 1'b0, 2'd0, 1'b0, 32'h0));
            end else if (i <= 4) begin
                drive((i == 2) ? 4'b1000 : 4'b0000, (i == 2), 1'b0, 32'h0BAD_0000, 32'h0, 1'b1);
                sb.push_back(mk(7'h7F, 1'b0, 1'b0, 2'd1, 1'b0, 32'h0));
            end else if (i == 5) begin
                drive(4'b0000, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
                sb.push_back(mk(7'h7F, 1'b0, 1'b0, 2'd1, 1'b0, 32'h0));
            end else if (i == 6) begin
                drive(4'b0000, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
                sb.push_back(mk(7'h00, 1'b1, 1'b1, 2'd2, 1'b0, 32'h1C00_2000));
            end else begin
                drive(4'b0000, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
                sb.push_back(mk(7'h00, 1'b0, 1'b0, 2'd0, 1'b0, 32'h0));
            end
            @(negedge clk);
            e = sb.pop_front(); o = obs(e.pc_chk); n_chk++;
            if (o !== e) $display("FAIL ertn_wait cyc %0d: got %h want %h", i, o, e);
            else n_pass++;
        end
    endtask

    task automatic test_rst_wait;
        for (int i = 0; i < 6; i++) begin
            next_cycle();
            case (i)
                0: begin
                    drive(4'b0000, 1'b1, 1'b0, 32'h1C00_0400, 32'h0, 1'b1);
                    sb.push_back(mk(7'h7F, 1'b0, 1'b0, 2'd0, 1'b0, 32'h0));
                end
                1: begin
                    drive(4'b0000, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
                    sb.push_back(mk(7'h7F, 1'b0, 1'b0, 2'd1, 1'b0, 32'h0));
                end
                2: begin
                    rst = 1'b0;
                    drive(4'b0000, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
                    sb.push_back(mk(7'h00, 1'b0, 1'b0, 2'd0, 1'b0, 32'h0));
                end
                default: begin
                    rst = 1'b1;
                    drive(4'b0000, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
                    sb.push_back(mk(7'h00, 1'b0, 1'b0, 2'd0, 1'b0, 32'h0));
                end
            endcase
            @(negedge clk);
            e = sb.pop_front(); o = obs(e.pc_chk); n_chk++;
            if (o !== e) $display("FAIL rst_wait cyc %0d: got %h want %h", i, o, e);
            else n_pass++;
        end
    endtask

    task automatic test_back_to_back;
        for (int i = 0; i < 5; i++) begin
            next_cycle();
            case (i)
                0: begin
                    drive(4'b0000, 1'b1, 1'b0, 32'h1C00_0800, 32'h0, 1'b0);
                    sb.push_back(mk(7'h7F, 1'b0, 1'b0, 2'd0, 1'b0, 32'h0));
                end
                1: begin
                    drive(4'b0000, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
                    sb.push_back(mk(7'h00, 1'b1, 1'b1, 2'd2, 1'b0, 32'h1C00_0800));
                end
                2: begin
                    drive(4'b0000, 1'b1, 1'b1, 32'h0, 32'h1C00_0900, 1'b0);
                    sb.push_back(mk(7'h7F, 1'b0, 1'b0, 2'd0, 1'b0, 32'h0));
                end
                3: begin
                    drive(4'b0000, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
                    sb.push_back(mk(7'h00, 1'b1, 1'b1, 2'd2, 1'b0, 32'h1C00_0900));
                end
                default: begin
                    drive(4'b0000, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
                    sb.push_back(mk(7'h00, 1'b0, 1'b0, 2'd0, 1'b0, 32'h0));
                end
            endcase
            @(negedge clk);
            e = sb.pop_front(); o = obs(e.pc_chk); n_chk++;
            if (o !== e) $display("FAIL back_to_back cyc %0d: got %h want %h", i, o, e);
            else n_pass++;
        end
`ifdef PIPE_CTRL_PERF_EN
        n_chk++;
        if (perf_flush_count !== 32'd2)
            $display("FAIL perf_flush: got %0d want 2", perf_flush_count);
        else n_pass++;
        n_chk++;
        if (perf_stall_cycles !== 32'd2)
            $display("FAIL perf_stall: got %0d want 2", perf_stall_cycles);
        else n_pass++;
`endif
    endtask

    task automatic test_timeout;
        logic req_on;
        for (int i = 0; i < 18; i++) begin
            req_on = (i < 7) || (i >= 8 && i < 16);
            next_cycle();
            drive(req_on ? 4'b1000 : 4'b0000, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
            sb.push_back(mk(req_on ? 7'b0111111 : 7'h00, 1'b0, 1'b0, 2'd0, (i >= 16), 32'h0));
            @(negedge clk);
            e = sb.pop_front(); o = obs(e.pc_chk); n_chk++;
            if (o !== e) $display("FAIL timeout cyc %0d: got %h want %h", i, o, e);
            else n_pass++;
        end
    endtask

    initial begin
        rst = 1'b0;
        drive(4'b1111, 1'b1, 1'b0, 32'h0, 32'h0, 1'b1);
        test_reset();
        test_stall_id();
        test_stall_combo();
        test_excp();
        test_ertn_wait();
        test_rst_wait();
        test_back_to_back();
        test_timeout();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
